// File: rtl/variable_delay_if.sv
// variable_delay_if: data/control bundle for the variable delay line.
interface variable_delay_if #(
  parameter int WIDTH      = 8,
  parameter int MAX_CYCLES = 16
);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  logic             en;
  logic             clear;
  logic [CW-1:0]    cycles;
  logic [WIDTH-1:0] in;
  logic             in_valid;
  logic [WIDTH-1:0] out;
  logic             out_valid;
  logic             cycles_err;
  modport master (output en, clear, cycles, in, in_valid, input out, out_valid, cycles_err);
  modport slave  (input en, clear, cycles, in, in_valid, output out, out_valid, cycles_err);
endinterface

// File: rtl/variable_delay.sv
// variable_delay: enable-gated shift pipe with a runtime-selected output tap.
module variable_delay #(
  parameter int               WIDTH       = 8,
  parameter int               MAX_CYCLES  = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input logic              clk,
  input logic              rst,
  variable_delay_if.slave  bus
);
  localparam int CW = $clog2(MAX_CYCLES + 1);
  if (WIDTH < 1 || MAX_CYCLES < 1) begin : g_bad_params
    $error("variable_delay: WIDTH and MAX_CYCLES must be >= 1");
  end
  logic [WIDTH-1:0]      data_q [MAX_CYCLES];
  logic [WIDTH-1:0]      data_d [MAX_CYCLES];
  logic [MAX_CYCLES-1:0] vld_q, vld_d;
  logic [CW-1:0]         d;
  logic [WIDTH-1:0]      tap_data;
  logic                  tap_vld;
  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (bus.clear) begin
      for (int i = 0; i < MAX_CYCLES; i++) data_d[i] = RESET_VALUE;
      vld_d = '0;
    end else if (bus.en) begin
      data_d[0] = bus.in;
      vld_d[0]  = bus.in_valid;
      for (int i = 1; i < MAX_CYCLES; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < MAX_CYCLES; i++) data_q[i] <= RESET_VALUE;
      vld_q <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end
  assign bus.cycles_err = bus.cycles > CW'(MAX_CYCLES);
  assign d = bus.cycles_err ? CW'(MAX_CYCLES) : bus.cycles;
  // D=0 bypasses the pipe; otherwise stage D-1 is the tap
  always_comb begin
    tap_data = bus.in;
    tap_vld  = bus.in_valid;
    for (int i = 0; i < MAX_CYCLES; i++) begin
      if (d == CW'(i + 1)) begin
        tap_data = data_q[i];
        tap_vld  = vld_q[i];
      end
    end
  end
  assign bus.out_valid = tap_vld;
  assign bus.out       = tap_vld ? tap_data : RESET_VALUE;
endmodule

// File: tb/tb_variable_delay.sv
// tb_variable_delay: directed checks of the variable delay line.
module tb_variable_delay;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int e;
  variable_delay_if #(.WIDTH(8), .MAX_CYCLES(16)) bus ();
  variable_delay #(.WIDTH(8), .MAX_CYCLES(16), .RESET_VALUE(8'h00)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #2;
  endtask
  task automatic flush();
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
  endtask
  initial begin
    bus.en = 1'b1; bus.clear = 1'b0; bus.cycles = 5'd4; bus.in = 8'h00; bus.in_valid = 1'b0;
    #1;
    check("reset_out", bus.out, 8'h00);
    check("reset_vld", bus.out_valid, 0);
    check("reset_err", bus.cycles_err, 0);
    @(negedge clk);
    rst = 1'b0;
    // stream 1,2,3,... at delay 4
    bus.in_valid = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      bus.in = 8'(t);
      tick();
      if (t < 4) check("s1_vld_lo", bus.out_valid, 0);
      else begin
        check("s1_vld", bus.out_valid, 1);
        check("s1_out", bus.out, 32'(t - 3));
      end
    end
    // en toggling: only enabled edges count
    flush();
    e = 0;
    for (int t = 0; t < 16; t++) begin
      bus.en = (t % 2 == 0);
      if (bus.en) begin
        e++;
        bus.in = 8'(8'h10 + e);
      end else bus.in = 8'hFF;
      tick();
      if (e < 4) check("s2_vld_lo", bus.out_valid, 0);
      else check("s2_out", {23'd0, bus.out_valid, bus.out}, {23'd0, 1'b1, 8'(8'h10 + e - 3)});
    end
    bus.en = 1'b1;
    // zero delay bypass
    bus.cycles = 5'd0; bus.in = 8'hA5; bus.in_valid = 1'b1;
    #1;
    check("d0_out", bus.out, 8'hA5);
    check("d0_vld", bus.out_valid, 1);
    bus.in_valid = 1'b0;
    #1;
    check("d0_out_inv", bus.out, 8'h00);
    check("d0_vld_inv", bus.out_valid, 0);
    // steady stream then widen the tap from 4 to 8
    bus.cycles = 5'd4;
    flush();
    bus.in_valid = 1'b1;
    for (int t = 1; t <= 10; t++) begin
      bus.in = 8'(8'h20 + t);
      tick();
    end
    check("s4_d4", bus.out, 8'h27);
    bus.cycles = 5'd8;
    #1;
    check("s4_d8", bus.out, 8'h23);
    check("s4_d8_vld", bus.out_valid, 1);
    bus.in = 8'hEE;
    flush();
    check("s4_clr_vld", bus.out_valid, 0);
    check("s4_clr_out", bus.out, 8'h00);
    for (int t = 1; t <= 8; t++) begin
      bus.in = 8'(8'h30 + t);
      tick();
      if (t < 8) check("s4_post_clr", bus.out_valid, 0);
      else check("s4_first", {23'd0, bus.out_valid, bus.out}, {23'd0, 1'b1, 8'h31});
    end
    // hold with en=0 keeps output stable
    bus.en = 1'b0; bus.in = 8'h99;
    tick(); tick();
    check("hold_out", bus.out, 8'h31);
    bus.en = 1'b1;
    // out-of-range delay clamps to 16
    bus.cycles = 5'd16;
    #1;
    check("err_16", bus.cycles_err, 0);
    bus.cycles = 5'd20;
    #1;
    check("err_20", bus.cycles_err, 1);
    flush();
    for (int t = 1; t <= 18; t++) begin
      bus.in = 8'(8'h40 + t);
      tick();
      if (t == 15) check("s5_vld_lo", bus.out_valid, 0);
      if (t >= 16) check("s5_out", {23'd0, bus.out_valid, bus.out}, {23'd0, 1'b1, 8'(8'h40 + t - 15)});
    end
    // async reset mid-stream
    bus.cycles = 5'd4;
    #1;
    check("s6_full", bus.out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("s6_rst_out", bus.out, 8'h00);
    check("s6_rst_vld", bus.out_valid, 0);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    tick(); tick();
    check("s6_idle", bus.out_valid, 0);
    bus.in_valid = 1'b1;
    for (int t = 1; t <= 5; t++) begin
      bus.in = 8'(8'h60 + t);
      tick();
      if (t < 4) check("s6_vld_lo", bus.out_valid, 0);
      else check("s6_out", {23'd0, bus.out_valid, bus.out}, {23'd0, 1'b1, 8'(8'h60 + t - 3)});
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
